// File: rtl/snap_mem_pkg.sv
// snap_mem_pkg
//   Shared definitions for the snapshot memory bridges.
//   - One-hot FSM state encoding (5 bits) with bit-index localparams.
//   - Read-latency legal range and a helper used as an elaboration check.
//   - Width of the read-latency down-counter.
package snap_mem_pkg;

    // Bit positions of the one-hot state vector.
    localparam int ST_INIT_BIT    = 0;
    localparam int ST_IDLE_BIT    = 1;
    localparam int ST_CMD_BIT     = 2;
    localparam int ST_RD_WAIT_BIT = 3;
    localparam int ST_ACK_BIT     = 4;
    localparam int ST_W           = 5;

    typedef enum logic [ST_W-1:0] {
        ST_INIT    = ST_W'(1 << ST_INIT_BIT),
        ST_IDLE    = ST_W'(1 << ST_IDLE_BIT),
        ST_CMD     = ST_W'(1 << ST_CMD_BIT),
        ST_RD_WAIT = ST_W'(1 << ST_RD_WAIT_BIT),
        ST_ACK     = ST_W'(1 << ST_ACK_BIT)
    } state_e;

    // SRAM read latency accepted by the bridges.
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Down-counter holds at most RD_LATENCY_MAX-1.
    localparam int LAT_CNT_W = 2;

    function automatic bit rd_latency_ok(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/snap_mem_init_ctr.sv
// snap_mem_init_ctr
//   Zero-fill sweep counter shared by the memory bridges. Counts every
//   enabled cycle through 0..2^IDX_WIDTH-1 and raises a sticky done flag on
//   the cycle after the last index has been issued.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (idx=0, done=0)
//   en    in   advance the sweep this cycle
//   idx   out  current sweep index
//   last  out  idx is the final index
//   done  out  sweep complete, held until reset
module snap_mem_init_ctr
    import snap_mem_pkg::*;
#(
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 last,
    output logic                 done
);

    assign last = &idx;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            idx  <= '0;
            done <= 1'b0;
        end else if (en) begin
            idx <= idx + 1'b1;
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snap_mem_bridge.sv
// snap_mem_bridge
//   Bridges the snapshot block's vld/rdy/ack request handshake onto a
//   single-port synchronous SRAM with fixed read latency. After every reset
//   the whole SRAM is zero-filled before the first request is accepted.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_req_vld/rdy     request handshake (accepted when both high)
//   mem_ack_vld         one-cycle completion pulse
//   mem_addr            byte address; low ENTRY_ADDR_LSB bits dropped
//   mem_rd_en/wr_en     operation select (both set = write + err pulse)
//   mem_wr_data         write data
//   mem_rd_data         registered read data, changes only on read capture
//   err                 one-cycle pulse for a request with both enables set
//   init_done           zero-fill complete
//   sram_cs/we/addr/wdata/rdata   SRAM port
module snap_mem_bridge
    import snap_mem_pkg::*;
#(
    parameter int MEM_WIDTH      = 36,
    parameter int ADDR_WIDTH     = 7,
    parameter int ENTRY_ADDR_LSB = 3,
    parameter int IDX_WIDTH      = ADDR_WIDTH - ENTRY_ADDR_LSB,
    parameter int RD_LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_vld,
    output logic                  mem_req_rdy,
    output logic                  mem_ack_vld,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_en,
    input  logic                  mem_wr_en,
    input  logic [MEM_WIDTH-1:0]  mem_wr_data,
    output logic [MEM_WIDTH-1:0]  mem_rd_data,
    output logic                  err,
    output logic                  init_done,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [IDX_WIDTH-1:0]  sram_addr,
    output logic [MEM_WIDTH-1:0]  sram_wdata,
    input  logic [MEM_WIDTH-1:0]  sram_rdata
);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("snap_mem_bridge: RD_LATENCY must be within 1..4");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LATENCY - 1);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   cmd_idx;
    logic                   cmd_rd_en;
    logic                   cmd_wr_en;
    logic [MEM_WIDTH-1:0]   cmd_wr_data;
    logic [LAT_CNT_W-1:0]   lat_cnt_q;
    logic [IDX_WIDTH-1:0]   init_idx;
    logic                   init_last;
    logic                   accept;
    logic                   capture;

    // Entry index ignores the byte offset within an entry.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[ENTRY_ADDR_LSB-1:0];

    assign accept  = (state_q == ST_IDLE) && mem_req_vld;
    assign capture = (state_q == ST_RD_WAIT) && (lat_cnt_q == '0);

    // NOTE: the SRAM array itself has no reset; it is cleared by the INIT
    // sweep, one entry per cycle, every time reset is released.
    snap_mem_init_ctr #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_init_ctr (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_INIT),
        .idx  (init_idx),
        .last (init_last),
        .done (init_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cmd_idx     <= '0;
            cmd_rd_en   <= 1'b0;
            cmd_wr_en   <= 1'b0;
            cmd_wr_data <= '0;
            lat_cnt_q   <= '0;
            mem_rd_data <= '0;
        end else begin
            state_q <= state_d;

            // Request fields are sampled only in the acceptance cycle.
            if (accept) begin
                cmd_idx     <= mem_addr[ADDR_WIDTH-1:ENTRY_ADDR_LSB];
                cmd_rd_en   <= mem_rd_en;
                cmd_wr_en   <= mem_wr_en;
                cmd_wr_data <= mem_wr_data;
            end

            // Loaded while the read is issued, expires in the last RD_WAIT cycle.
            if (state_q == ST_CMD) begin
                lat_cnt_q <= LAT_LOAD;
            end else if ((state_q == ST_RD_WAIT) && (lat_cnt_q != '0)) begin
                lat_cnt_q <= lat_cnt_q - 1'b1;
            end

            if (capture) begin
                mem_rd_data <= sram_rdata;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        mem_req_rdy = 1'b0;
        mem_ack_vld = 1'b0;
        err         = 1'b0;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = cmd_idx;
        sram_wdata  = cmd_wr_data;

        unique case (state_q)
            ST_INIT: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = init_idx;
                sram_wdata = '0;
                if (init_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                mem_req_rdy = 1'b1;
                if (mem_req_vld) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                err = cmd_rd_en && cmd_wr_en;
                if (cmd_wr_en) begin
                    // Both enables set is executed as a write.
                    sram_cs = 1'b1;
                    sram_we = 1'b1;
                    state_d = ST_ACK;
                end else if (cmd_rd_en) begin
                    sram_cs = 1'b1;
                    state_d = ST_RD_WAIT;
                end else begin
                    // Invalid-entry read: complete without touching the SRAM.
                    state_d = ST_ACK;
                end
            end
            ST_RD_WAIT: begin
                if (capture) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                mem_ack_vld = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_snap_mem_bridge.sv
// tb_snap_mem_bridge
//   Directed bench for snap_mem_bridge with DEPTH=16 and RD_LATENCY=2.
//   A behavioural two-stage SRAM model returns JUNK whenever no read was
//   issued, so a capture in the wrong cycle is visible.
module tb_snap_mem_bridge;

    localparam int MEM_WIDTH  = 36;
    localparam int ADDR_WIDTH = 7;
    localparam int LSB        = 3;
    localparam int IDX_WIDTH  = ADDR_WIDTH - LSB;
    localparam int DEPTH      = 1 << IDX_WIDTH;
    localparam int RD_LAT     = 2;

    localparam logic [MEM_WIDTH-1:0] JUNK = 36'hB_AD0B_AD00;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mem_req_vld;
    logic                  mem_req_rdy;
    logic                  mem_ack_vld;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [MEM_WIDTH-1:0]  mem_wr_data;
    logic [MEM_WIDTH-1:0]  mem_rd_data;
    logic                  err;
    logic                  init_done;
    logic                  sram_cs;
    logic                  sram_we;
    logic [IDX_WIDTH-1:0]  sram_addr;
    logic [MEM_WIDTH-1:0]  sram_wdata;
    logic [MEM_WIDTH-1:0]  sram_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snap_mem_bridge #(
        .MEM_WIDTH      (MEM_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ENTRY_ADDR_LSB (LSB),
        .RD_LATENCY     (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req_vld (mem_req_vld),
        .mem_req_rdy (mem_req_rdy),
        .mem_ack_vld (mem_ack_vld),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .err         (err),
        .init_done   (init_done),
        .sram_cs     (sram_cs),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    // SRAM model: seeded with non-zero contents, two read pipeline stages.
    logic [MEM_WIDTH-1:0] sram [DEPTH];
    logic [MEM_WIDTH-1:0] rd_stage0 = JUNK;
    logic [MEM_WIDTH-1:0] rd_stage1 = JUNK;
    logic                 seeded    = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) begin
                sram[i] <= 36'hF_0000_0000 | MEM_WIDTH'(i + 1);
            end
            seeded <= 1'b1;
        end else if (sram_cs && sram_we) begin
            sram[sram_addr] <= sram_wdata;
        end
        rd_stage0 <= (sram_cs && !sram_we) ? sram[sram_addr] : JUNK;
        rd_stage1 <= rd_stage0;
    end

    assign sram_rdata = rd_stage1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [ADDR_WIDTH-1:0] addr,
                         input logic rd, input logic wr, input logic [MEM_WIDTH-1:0] data);
        mem_req_vld = vld;
        mem_addr    = addr;
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_wr_data = data;
    endtask

    logic [MEM_WIDTH-1:0] mem_or;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (3) tick();
        rst = 1'b0;

        // ---- Reset / zero-fill: cycle 0 is the first cycle out of reset.
        check("reset_outputs", {mem_req_rdy, mem_ack_vld, err, init_done, mem_rd_data},
              {4'b0000, 36'h0});
        for (int i = 0; i < DEPTH; i++) begin
            check("init_write", {mem_req_rdy, init_done, sram_cs, sram_we, sram_addr, sram_wdata},
                  {4'b0011, 4'(i), 36'h0});
            tick();
        end
        check("init_done_c16", {init_done, mem_req_rdy}, 2'b11);
        mem_or = '0;
        for (int i = 0; i < DEPTH; i++) mem_or = mem_or | sram[i];
        check("sram_zeroed", 64'(mem_or), 64'h0);

        // ---- Write 0x18 (index 3); T = cycle 16.
        drive(1'b1, 7'h18, 1'b0, 1'b1, 36'h9_1234_5678);
        tick();                                           // T+1
        check("wr_sram_access", {sram_cs, sram_we, sram_addr, sram_wdata, err, mem_ack_vld},
              {2'b11, 4'd3, 36'h9_1234_5678, 2'b00});
        drive(1'b0, 7'h00, 1'b1, 1'b0, 36'h0);            // ignored after acceptance
        tick();                                           // T+2
        check("wr_ack", {mem_ack_vld, mem_req_rdy, sram_cs, mem_rd_data}, {3'b100, 36'h0});
        tick();                                           // T+3
        check("wr_rdy_again", {mem_ack_vld, mem_req_rdy}, 2'b01);

        // ---- Read 0x18 with RD_LATENCY=2: ack in T+4.
        drive(1'b1, 7'h18, 1'b1, 1'b0, 36'h0);
        tick();                                           // T+1
        check("rd_sram_access", {sram_cs, sram_we, sram_addr, err}, {2'b10, 4'd3, 1'b0});
        drive(1'b0, 7'h7F, 1'b0, 1'b1, 36'h1_1111_1111);
        tick();                                           // T+2
        check("rd_wait1", {mem_ack_vld, sram_cs, mem_rd_data}, {2'b00, 36'h0});
        tick();                                           // T+3
        check("rd_wait2", {mem_ack_vld, sram_cs, mem_rd_data}, {2'b00, 36'h0});
        tick();                                           // T+4
        check("rd_ack_data", {mem_ack_vld, mem_rd_data}, {1'b1, 36'h9_1234_5678});
        repeat (10) tick();
        check("rd_data_held", {mem_ack_vld, mem_req_rdy, mem_rd_data}, {2'b01, 36'h9_1234_5678});

        // ---- No-op (neither enable): ack in T+2, no SRAM access.
        drive(1'b1, 7'h18, 1'b0, 1'b0, 36'h3_3333_3333);
        tick();                                           // T+1
        check("noop_no_cs", {sram_cs, err, mem_ack_vld}, 3'b000);
        drive(1'b0, 7'h00, 1'b0, 1'b0, 36'h0);
        tick();                                           // T+2
        check("noop_ack", {mem_ack_vld, sram_cs, mem_rd_data}, {2'b10, 36'h9_1234_5678});
        tick();                                           // T+3

        // ---- Both enables: err in T+1, executed as a write to index 5.
        drive(1'b1, 7'h28, 1'b1, 1'b1, 36'h5);
        tick();                                           // T+1
        check("both_err_write", {err, sram_cs, sram_we, sram_addr, sram_wdata},
              {3'b111, 4'd5, 36'h5});
        drive(1'b0, 7'h00, 1'b0, 1'b0, 36'h0);
        tick();                                           // T+2
        check("both_ack", {err, mem_ack_vld, mem_rd_data}, {2'b01, 36'h9_1234_5678});
        tick();                                           // T+3
        drive(1'b1, 7'h28, 1'b1, 1'b0, 36'h0);
        repeat (4) tick();                                // read ack at T+4
        check("both_readback", {mem_ack_vld, mem_rd_data}, {1'b1, 36'h5});
        drive(1'b0, 7'h00, 1'b0, 1'b0, 36'h0);
        tick();

        // ---- Request held while busy; inputs changed after acceptance.
        drive(1'b1, 7'h38, 1'b0, 1'b1, 36'hA_AAAA_AAAA);
        tick();                                           // T+1
        drive(1'b1, 7'h08, 1'b0, 1'b1, 36'h1);
        check("busy_first_cmd", {sram_cs, sram_we, sram_addr, sram_wdata, mem_req_rdy},
              {2'b11, 4'd7, 36'hA_AAAA_AAAA, 1'b0});
        tick();                                           // T+2
        check("busy_not_rdy", {mem_ack_vld, mem_req_rdy}, 2'b10);
        tick();                                           // T+3: second acceptance
        check("busy_rdy", mem_req_rdy, 1'b1);
        tick();                                           // T+4
        check("busy_second_cmd", {sram_cs, sram_we, sram_addr, sram_wdata}, {2'b11, 4'd1, 36'h1});
        drive(1'b0, 7'h00, 1'b0, 1'b0, 36'h0);
        repeat (2) tick();

        // ---- Reset in RD_WAIT: read index 7, reset at T+2.
        check("pre_reset_idle", mem_req_rdy, 1'b1);
        drive(1'b1, 7'h38, 1'b1, 1'b0, 36'h0);
        tick();                                           // T+1
        drive(1'b0, 7'h00, 1'b0, 1'b0, 36'h0);
        tick();                                           // T+2 (RD_WAIT)
        rst = 1'b1;
        tick();                                           // reset taken
        rst = 1'b0;
        // Request held throughout the new INIT sweep.
        drive(1'b1, 7'h38, 1'b1, 1'b0, 36'h0);
        check("abort_state", {mem_ack_vld, init_done, mem_rd_data}, {2'b00, 36'h0});
        for (int i = 0; i < DEPTH; i++) begin
            check("reinit_write", {mem_req_rdy, mem_ack_vld, sram_cs, sram_we, sram_addr},
                  {4'b0011, 4'(i)});
            tick();
        end
        check("reinit_rdy", {init_done, mem_req_rdy}, 2'b11);   // accepted here
        tick();                                                  // T+1
        check("held_rd_issue", {sram_cs, sram_we, sram_addr}, {2'b10, 4'd7});
        drive(1'b0, 7'h00, 1'b0, 1'b0, 36'h0);
        repeat (3) tick();                                       // T+4
        check("reinit_readback", {mem_ack_vld, mem_rd_data}, {1'b1, 36'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snap_mem_bridge.md
# snap_mem_bridge

Memory-side bridge directly downstream of the snapshot register block. It accepts the `mem_req_vld`/`mem_req_rdy`/`mem_ack_vld` request handshake and drives a single-port synchronous SRAM with a fixed read latency. It returns read data held stable for the snapshot capture. After every reset it zero-initialises the whole SRAM before accepting any request.

## Interface
Parameters:
- `MEM_WIDTH`, 36: entry width, equal to the upstream `MEM_WIDTH`.
- `ADDR_WIDTH`, 7: byte-address width of `mem_addr`.
- `ENTRY_ADDR_LSB`, 3: low address bits dropped to form the entry index.
- `IDX_WIDTH`, `ADDR_WIDTH-ENTRY_ADDR_LSB`: SRAM index width. `DEPTH` = 2^`IDX_WIDTH`.
- `RD_LATENCY`, 1: SRAM cycles from `sram_cs` to valid `sram_rdata`. Legal range is 1..4.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req_vld`  in  1  request valid.
- `mem_req_rdy`  out  1  bridge can accept.
- `mem_ack_vld`  out  1  one-cycle completion pulse.
- `mem_addr`  in  ADDR_WIDTH  byte address.
- `mem_rd_en`  in  1  read request.
- `mem_wr_en`  in  1  write request.
- `mem_wr_data`  in  MEM_WIDTH  write data.
- `mem_rd_data`  out  MEM_WIDTH  read data (registered).
- `err`  out  1  one-cycle pulse when `rd_en` and `wr_en` are both set.
- `init_done`  out  1  high once zero-fill is complete.
- `sram_cs`  out  1  SRAM chip select.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  IDX_WIDTH  SRAM index.
- `sram_wdata`  out  MEM_WIDTH  SRAM write data.
- `sram_rdata`  in  MEM_WIDTH  SRAM read data.

## Operation
- FSM states are INIT, IDLE, CMD, RD_WAIT and ACK.
- After reset the FSM is in INIT, which zero-fills the SRAM:
  - One write per cycle to indices 0..DEPTH-1, with `sram_wdata`=0.
  - On the write of index DEPTH-1 the next state is IDLE and `init_done` is set. `init_done` then stays 1 until reset.
- Acceptance: a request is accepted when the state is IDLE and `mem_req_vld` is 1. `mem_req_rdy` = (state==IDLE).
- On acceptance, latch into the command register:
  - index = `mem_addr[ADDR_WIDTH-1:ENTRY_ADDR_LSB]`,
  - `mem_rd_en`, `mem_wr_en`, `mem_wr_data`.
- CMD state, which lasts one cycle:
  - Write (`wr_en`=1, including `rd_en`=1 with `wr_en`=1): `sram_cs`=`sram_we`=1, then go to ACK.
  - Read only: `sram_cs`=1, `sram_we`=0, then go to RD_WAIT.
  - Neither enable set (an invalid-entry read): no SRAM access, then go to ACK.
- `err` pulses in the CMD cycle when both enables are set. The operation is executed as a write.
- RD_WAIT: a down-counter counts RD_LATENCY-1 cycles, then the FSM loads `sram_rdata` into `mem_rd_data` and goes to ACK.
- ACK: `mem_ack_vld`=1 for exactly one cycle, then the FSM goes to IDLE.
- `mem_rd_data` changes only on a read capture or on reset. It holds its value through writes, no-ops and idle periods.
- The upstream block must hold `mem_req_vld` until accepted. Addr, enables and data are sampled only in the acceptance cycle. Later changes to them are ignored.

## Timing
- Let T be the acceptance cycle.
- Write: SRAM write in cycle T+1, `mem_ack_vld` in T+2, `mem_req_rdy` high again in T+3.
- No-op: `mem_ack_vld` in T+2, with no `sram_cs`.
- Read:
  - `sram_cs` in T+1.
  - Capture at the end of cycle T+RD_LATENCY+1 (the RD_WAIT cycle in which the counter expires; with RD_LATENCY=1 this is the single RD_WAIT cycle).
  - `mem_ack_vld` and valid `mem_rd_data` both appear in T+RD_LATENCY+2.
  - `mem_rd_data` stays valid after the ack, until the next read capture.
- Throughput is one request every 3 cycles (write or no-op) or every RD_LATENCY+3 cycles (read).
- Reset values:
  - `mem_req_rdy`=0, `mem_ack_vld`=0, `mem_rd_data`=0, `err`=0, `init_done`=0.
  - `sram_cs` is 1 from the first INIT cycle; `sram_we`=1, `sram_addr`=0, `sram_wdata`=0.
  - In all non-INIT, non-CMD states: `sram_cs`=0, `sram_we`=0.
- INIT lasts exactly DEPTH cycles, and the first `mem_req_rdy` appears in cycle DEPTH after reset deasserts.
- Reset asserted mid-operation aborts any pending access: no ack is issued and the FSM re-enters INIT.
- `mem_req_vld` asserted during INIT is not accepted until IDLE is reached.

## Structure
- Shared package `snap_mem_pkg`:
  - state encoding constants (one-hot, 5 bits, bit-index localparams in the codebase's existing style),
  - the RD_LATENCY legal-range check.
- Sub-module `snap_mem_init_ctr`: the IDX_WIDTH-bit zero-fill counter with a `done` flag. It is reused by other memory bridges.
- The read-latency counter and the FSM live in the top module.

## Test plan
- Reset, DEPTH=16: 16 consecutive zero-writes to indices 0..15, then `init_done`=1 and `mem_req_rdy`=1 in cycle 16.
- Write `mem_addr`=0x18, data=0x9_1234_5678, then read 0x18 with RD_LATENCY=2:
  - SRAM writes index 3,
  - ack in T+4 with `mem_rd_data`=0x9_1234_5678,
  - data held 10 idle cycles later.
- Read with neither enable set: ack in T+2, no `sram_cs`, `mem_rd_data` unchanged.
- `rd_en`=`wr_en`=1, data=0x5: `err` pulse in T+1, write performed, a subsequent read returns 0x5.
- Request held during INIT and while busy: acceptance only in IDLE; inputs changed after acceptance have no effect.
- Reset asserted in RD_WAIT: no `mem_ack_vld`, INIT restarts from index 0, `mem_rd_data`=0.
